apu_dispatcher: RTL and testbench
=================================

# apu_dispatcher

Core-side initiator for the vector accelerator's APU request/response interface. It accepts one vector instruction at a time from the scalar core's issue stage and presents it to the accelerator decoder together with two scalar operands. It holds the request until grant, waits for the completion pulse, captures the 32-bit result and returns it to the core's writeback with a scalar-writeback qualifier. There is a single outstanding instruction; the block is the opposite end of the accelerator's APU responder.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles. Used only when `APU_TIMEOUT_EN` is defined.
- `clk` in 1: clock; all state updates on the rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `instr_valid_i` in 1: core offers an instruction.
- `instr_ready_o` out 1: dispatcher can accept an instruction.
- `instr_i` in 32: vector instruction word.
- `rs1_i`, `rs2_i` in 32 each: scalar operand values.
- `rd_addr_i` in 5: scalar destination register.
- `flags_i` in 15: passed through to `apu_flags_o`.
- `apu_req` out 1: request to the accelerator.
- `apu_gnt` in 1: accelerator accepts the request.
- `apu_operands[2:0]` out 3×32: [0]=rs1, [1]=rs2, [2]=instruction.
- `apu_op` out 6: `instr[31:26]`.
- `apu_flags_o` out 15: registered copy of `flags_i`.
- `apu_rvalid` in 1: single-cycle completion pulse.
- `apu_result` in 32: result, valid when `apu_rvalid` is high.
- `result_valid_o` out 1, `result_ready_i` in 1: result handshake toward writeback.
- `result_o` out 32: captured result.
- `result_rd_o` out 5: destination register for the result.
- `result_wb_o` out 1: scalar register write required.
- `busy_o` out 1: high whenever the state is not IDLE.
- `instr_count_o` out 32: number of completed instructions; wraps.
- `timeout_err_o` out 1: sticky watchdog flag. Present only with `APU_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, RESP.
- **IDLE**
  - `instr_ready_o`=1.
  - On `instr_valid_i`: register instr, rs1, rs2, rd, flags and the writeback decode, then go to REQ.
- **REQ**
  - `apu_req`=1; operands, op and flags are driven from the registers and stay stable.
  - On `apu_gnt`: go to WAIT_RSP.
  - `apu_req` is never withdrawn without a grant.
- **WAIT_RSP**
  - `apu_req`=0.
  - On `apu_rvalid`: capture `apu_result` into `result_o` and go to RESP.
- **RESP**
  - `result_valid_o`=1.
  - On `result_ready_i`: increment `instr_count_o` and go to IDLE.
  - `result_o`, `result_rd_o` and `result_wb_o` hold stable until the handshake completes.
- Writeback decode: `result_wb_o`=1 only when `instr[6:0]`=7'b1010111 AND `rd`≠0 AND one of:
  - funct3=3'b111 (vsetvli), or
  - funct3=3'b010 with funct6=6'b010000 (vmv.x.s).
- All other instructions, including vector loads and stores: `result_wb_o`=0. The result handshake still occurs so the core can retire the instruction.
- `apu_rvalid` or `apu_gnt` arriving in a state that does not expect it is ignored.
- Reset values: `apu_req`=0, `instr_ready_o`=0, `result_valid_o`=0, `busy_o`=0, `timeout_err_o`=0. All data outputs and `instr_count_o` reset to 0. State resets to IDLE.
- `instr_ready_o` is combinational from state and is 1 in IDLE only.

## Timing
- `instr_valid_i`&`instr_ready_o` in cycle N: `apu_req`=1 in N+1.
- Grant in cycle M: `apu_req`=0 in M+1.
- `apu_rvalid` never coincides with the grant cycle.
- `apu_rvalid` in cycle K: `result_valid_o`=1 in K+1.
- Minimum turnaround is 4 cycles per instruction, reached when grant, response and ready each arrive immediately.
- Asserting `n_reset` at any point aborts the in-flight instruction: `apu_req` drops immediately and no result is produced.

## Configuration
- `APU_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to WAIT_RSP and increments each cycle in WAIT_RSP.
  - If `apu_rvalid` has not arrived when the counter reaches `TIMEOUT_CYCLES`-1: set `timeout_err_o` (sticky until reset), go to RESP with `result_o`=0 and `result_wb_o`=0.
  - A late `apu_rvalid` after the timeout is ignored.
- `APU_TIMEOUT_EN` undefined: no counter and no `timeout_err_o` port; WAIT_RSP waits indefinitely.

## Test plan
- vsetvli 0x0C0572D7 (rd=5, funct3=111), rs1=7; grant immediate, `apu_result`=4 two cycles later → `result_o`=4, `result_rd_o`=5, `result_wb_o`=1, `instr_count_o`=1.
- vadd.vv (funct6=0, rd field=3) with `apu_gnt` held low for 5 cycles → `apu_req` high and `apu_operands` stable for 6 cycles; `result_wb_o`=0.
- vmv.x.s with rd=0 → `result_wb_o`=0 while `result_valid_o` still pulses. `result_ready_i` held low for 3 cycles → outputs stable throughout; `instr_ready_o`=0 until the handshake completes.
- Spurious `apu_rvalid` in IDLE and in REQ → no state change and no result.
- Reset asserted during WAIT_RSP → all outputs go to reset values asynchronously; the next instruction completes normally.
- `APU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, no `apu_rvalid` → `result_valid_o` 17 cycles after grant, `result_o`=0, `timeout_err_o`=1 sticky.

Source files
------------

// File: rtl/apu_dispatcher_if.sv
// ---------------------------------------------------------------------------
// apu_dispatcher_if
//   APU request/response bus between the core-side dispatcher (master) and
//   the vector accelerator's APU responder (slave).
//
//   apu_req       master->slave  request, held until apu_gnt
//   apu_gnt       slave->master  request accepted
//   apu_operands  master->slave  [0]=rs1, [1]=rs2, [2]=instruction word
//   apu_op        master->slave  instr[31:26]
//   apu_flags_o   master->slave  registered core flags
//   apu_rvalid    slave->master  single-cycle completion pulse
//   apu_result    slave->master  result, valid with apu_rvalid
// ---------------------------------------------------------------------------
interface apu_dispatcher_if;
   logic              apu_req;
   logic              apu_gnt;
   logic [2:0][31:0]  apu_operands;
   logic [5:0]        apu_op;
   logic [14:0]       apu_flags_o;
   logic              apu_rvalid;
   logic [31:0]       apu_result;

   modport master (
      output apu_req,
      output apu_operands,
      output apu_op,
      output apu_flags_o,
      input  apu_gnt,
      input  apu_rvalid,
      input  apu_result
   );

   modport slave (
      input  apu_req,
      input  apu_operands,
      input  apu_op,
      input  apu_flags_o,
      output apu_gnt,
      output apu_rvalid,
      output apu_result
   );
endinterface

// File: rtl/apu_dispatcher.sv
// ---------------------------------------------------------------------------
// apu_dispatcher
//   Core-side initiator for the vector accelerator APU interface. Accepts one
//   vector instruction from the issue stage, requests the accelerator with
//   two scalar operands, waits for the completion pulse, and hands the
//   captured result to writeback. One instruction outstanding at a time.
//
// Ports
//   clk, n_reset          clock, asynchronous active-low reset
//   instr_valid_i/ready_o issue handshake (ready only in IDLE)
//   instr_i, rs1_i, rs2_i instruction word and scalar operands
//   rd_addr_i, flags_i    destination register, flags for the accelerator
//   apu                   APU bus (master modport of apu_dispatcher_if)
//   result_valid_o/ready_i writeback handshake
//   result_o, result_rd_o, result_wb_o  captured result, rd, scalar-write qualifier
//   busy_o                high whenever not IDLE
//   instr_count_o         completed instruction count (wraps)
//   timeout_err_o         sticky watchdog flag (APU_TIMEOUT_EN only)
//
// Configuration
//   APU_TIMEOUT_EN  when defined, a watchdog in WAIT_RSP forces a zero
//                   result after TIMEOUT_CYCLES cycles without apu_rvalid.
// ---------------------------------------------------------------------------
module apu_dispatcher #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic                instr_valid_i,
   output logic                instr_ready_o,
   input  logic [31:0]         instr_i,
   input  logic [31:0]         rs1_i,
   input  logic [31:0]         rs2_i,
   input  logic [4:0]          rd_addr_i,
   input  logic [14:0]         flags_i,
   apu_dispatcher_if.master    apu,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [31:0]         result_o,
   output logic [4:0]          result_rd_o,
   output logic                result_wb_o,
   output logic                busy_o,
   output logic [31:0]         instr_count_o
`ifdef APU_TIMEOUT_EN
   ,
   output logic                timeout_err_o
`endif
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REQ      = 2'd1;
   localparam logic [1:0] WAIT_RSP = 2'd2;
   localparam logic [1:0] RESP     = 2'd3;

   // Scalar register write is needed only for vsetvli and vmv.x.s with rd!=0.
   function automatic logic is_scalar_wb(input logic [31:0] instr, input logic [4:0] rd);
      logic op_v;
      logic setvl;
      logic mv_x_s;
      op_v   = (instr[6:0] == 7'b1010111);
      setvl  = (instr[14:12] == 3'b111);
      mv_x_s = (instr[14:12] == 3'b010) && (instr[31:26] == 6'b010000);
      return op_v && (rd != 5'd0) && (setvl || mv_x_s);
   endfunction

   logic [1:0]  state_q,  state_d;
   logic [31:0] instr_q,  instr_d;
   logic [31:0] rs1_q,    rs1_d;
   logic [31:0] rs2_q,    rs2_d;
   logic [4:0]  rd_q,     rd_d;
   logic [14:0] flags_q,  flags_d;
   logic        wb_q,     wb_d;
   logic [31:0] result_q, result_d;
   logic [31:0] count_q,  count_d;

`ifdef APU_TIMEOUT_EN
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_err_q, tmo_err_d;
`endif

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      flags_d  = flags_q;
      wb_d     = wb_q;
      result_d = result_q;
      count_d  = count_q;
`ifdef APU_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      tmo_err_d = tmo_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (instr_valid_i) begin
               instr_d = instr_i;
               rs1_d   = rs1_i;
               rs2_d   = rs2_i;
               rd_d    = rd_addr_i;
               flags_d = flags_i;
               wb_d    = is_scalar_wb(instr_i, rd_addr_i);
               state_d = REQ;
            end
         end
         REQ: begin
            if (apu.apu_gnt) begin
               state_d = WAIT_RSP;
`ifdef APU_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         WAIT_RSP: begin
            if (apu.apu_rvalid) begin
               result_d = apu.apu_result;
               state_d  = RESP;
            end
`ifdef APU_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               // Give the core a zero, non-writing result so it can retire.
               result_d  = '0;
               wb_d      = 1'b0;
               tmo_err_d = 1'b1;
               state_d   = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            if (result_ready_i) begin
               count_d = count_q + 32'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q  <= IDLE;
         instr_q  <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         flags_q  <= '0;
         wb_q     <= 1'b0;
         result_q <= '0;
         count_q  <= '0;
`ifdef APU_TIMEOUT_EN
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         flags_q  <= flags_d;
         wb_q     <= wb_d;
         result_q <= result_d;
         count_q  <= count_d;
`ifdef APU_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
`endif
      end
   end

   // Ready is gated by reset so it reads 0 while reset is held, even though
   // the state register already sits in IDLE.
   assign instr_ready_o    = (state_q == IDLE) && n_reset;
   assign busy_o           = (state_q != IDLE);
   assign result_valid_o   = (state_q == RESP);

   // Request decodes straight from state so reset withdraws it immediately.
   assign apu.apu_req      = (state_q == REQ);
   assign apu.apu_operands = {instr_q, rs2_q, rs1_q};
   assign apu.apu_op       = instr_q[31:26];
   assign apu.apu_flags_o  = flags_q;

   assign result_o         = result_q;
   assign result_rd_o      = rd_q;
   assign result_wb_o      = wb_q;
   assign instr_count_o    = count_q;

`ifdef APU_TIMEOUT_EN
   assign timeout_err_o    = tmo_err_q;
`endif

endmodule

// File: tb/tb_apu_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_apu_dispatcher
//   Directed bench for apu_dispatcher. Inputs change 1 time unit after the
//   rising edge; outputs are checked there too, away from the clock edge.
// ---------------------------------------------------------------------------
module tb_apu_dispatcher;

   logic        clk;
   logic        n_reset;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [31:0] instr_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [4:0]  rd_addr_i;
   logic [14:0] flags_i;
   logic        result_valid_o;
   logic        result_ready_i;
   logic [31:0] result_o;
   logic [4:0]  result_rd_o;
   logic        result_wb_o;
   logic        busy_o;
   logic [31:0] instr_count_o;
`ifdef APU_TIMEOUT_EN
   logic        timeout_err_o;
`endif

   int errors = 0;
   int checks = 0;

   apu_dispatcher_if bus();

`ifdef APU_TIMEOUT_EN
   apu_dispatcher #(.TIMEOUT_CYCLES(16)) dut (
`else
   apu_dispatcher dut (
`endif
      .clk            (clk),
      .n_reset        (n_reset),
      .instr_valid_i  (instr_valid_i),
      .instr_ready_o  (instr_ready_o),
      .instr_i        (instr_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .rd_addr_i      (rd_addr_i),
      .flags_i        (flags_i),
      .apu            (bus),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .result_rd_o    (result_rd_o),
      .result_wb_o    (result_wb_o),
      .busy_o         (busy_o),
      .instr_count_o  (instr_count_o)
`ifdef APU_TIMEOUT_EN
      ,
      .timeout_err_o  (timeout_err_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_reset        = 1'b1;
      instr_valid_i  = 1'b0;
      instr_i        = '0;
      rs1_i          = '0;
      rs2_i          = '0;
      rd_addr_i      = '0;
      flags_i        = '0;
      result_ready_i = 1'b0;
      bus.apu_gnt    = 1'b0;
      bus.apu_rvalid = 1'b0;
      bus.apu_result = '0;
      #1 n_reset = 1'b0;
      #1;

      // ---- reset values ----
      chk("rst_instr_ready", 32'(instr_ready_o), 32'd0);
      chk("rst_apu_req", 32'(bus.apu_req), 32'd0);
      chk("rst_result_valid", 32'(result_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_count", instr_count_o, 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_wb", 32'(result_wb_o), 32'd0);
      chk("rst_operand2", bus.apu_operands[2], 32'd0);
`ifdef APU_TIMEOUT_EN
      chk("rst_timeout_err", 32'(timeout_err_o), 32'd0);
`endif
      step();
      n_reset = 1'b1;
      #1;
      chk("idle_ready", 32'(instr_ready_o), 32'd1);

      // ---- vsetvli, immediate grant, result two cycles after grant ----
      instr_valid_i = 1'b1;
      instr_i       = 32'h0C0572D7;
      rs1_i         = 32'd7;
      rs2_i         = 32'h11;
      rd_addr_i     = 5'd5;
      flags_i       = 15'h1234;
      step();
      instr_valid_i = 1'b0;
      instr_i       = 32'hFFFFFFFF;
      rs1_i         = 32'h0;
      chk("t1_req", 32'(bus.apu_req), 32'd1);
      chk("t1_ready_low", 32'(instr_ready_o), 32'd0);
      chk("t1_busy", 32'(busy_o), 32'd1);
      chk("t1_op", 32'(bus.apu_op), 32'd3);
      chk("t1_opnd0", bus.apu_operands[0], 32'd7);
      chk("t1_opnd1", bus.apu_operands[1], 32'h11);
      chk("t1_opnd2", bus.apu_operands[2], 32'h0C0572D7);
      chk("t1_flags", 32'(bus.apu_flags_o), 32'h1234);
      bus.apu_gnt = 1'b1;
      step();
      bus.apu_gnt = 1'b0;
      chk("t1_req_drop", 32'(bus.apu_req), 32'd0);
      step();
      chk("t1_wait_no_result", 32'(result_valid_o), 32'd0);
      bus.apu_rvalid = 1'b1;
      bus.apu_result = 32'd4;
      step();
      bus.apu_rvalid = 1'b0;
      bus.apu_result = 32'hBAD0BAD0;
      chk("t1_rvalid", 32'(result_valid_o), 32'd1);
      chk("t1_result", result_o, 32'd4);
      chk("t1_rd", 32'(result_rd_o), 32'd5);
      chk("t1_wb", 32'(result_wb_o), 32'd1);
      result_ready_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      chk("t1_rvalid_drop", 32'(result_valid_o), 32'd0);
      chk("t1_count", instr_count_o, 32'd1);
      chk("t1_back_idle", 32'(instr_ready_o), 32'd1);
      chk("t1_not_busy", 32'(busy_o), 32'd0);

      // ---- vadd.vv, grant withheld for 5 cycles ----
      instr_valid_i = 1'b1;
      instr_i       = 32'h021101D7;
      rs1_i         = 32'hA5A5A5A5;
      rs2_i         = 32'h5A5A5A5A;
      rd_addr_i     = 5'd3;
      flags_i       = 15'h7FFF;
      step();
      instr_valid_i = 1'b0;
      instr_i       = 32'h0;
      rs1_i         = 32'h0;
      for (int i = 0; i < 6; i++) begin
         chk("t2_req_held", 32'(bus.apu_req), 32'd1);
         chk("t2_opnd0_stable", bus.apu_operands[0], 32'hA5A5A5A5);
         chk("t2_opnd2_stable", bus.apu_operands[2], 32'h021101D7);
         if (i == 5) bus.apu_gnt = 1'b1;
         step();
      end
      bus.apu_gnt = 1'b0;
      chk("t2_req_drop", 32'(bus.apu_req), 32'd0);
      bus.apu_rvalid = 1'b1;
      bus.apu_result = 32'hDEADBEEF;
      step();
      bus.apu_rvalid = 1'b0;
      chk("t2_rvalid", 32'(result_valid_o), 32'd1);
      chk("t2_result", result_o, 32'hDEADBEEF);
      chk("t2_rd", 32'(result_rd_o), 32'd3);
      chk("t2_wb", 32'(result_wb_o), 32'd0);
      result_ready_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      chk("t2_count", instr_count_o, 32'd2);

      // ---- spurious rvalid in IDLE ----
      bus.apu_rvalid = 1'b1;
      bus.apu_result = 32'h55;
      step();
      bus.apu_rvalid = 1'b0;
      chk("sp_idle_busy", 32'(busy_o), 32'd0);
      chk("sp_idle_rvalid", 32'(result_valid_o), 32'd0);
      chk("sp_idle_result", result_o, 32'hDEADBEEF);

      // ---- vmv.x.s rd=0, spurious rvalid in REQ, ready held low ----
      instr_valid_i = 1'b1;
      instr_i       = 32'h42202057;
      rs1_i         = 32'h1;
      rs2_i         = 32'h2;
      rd_addr_i     = 5'd0;
      flags_i       = 15'h0;
      step();
      instr_valid_i = 1'b0;
      chk("t3_op", 32'(bus.apu_op), 32'h10);
      bus.apu_rvalid = 1'b1;
      bus.apu_result = 32'h66;
      step();
      bus.apu_rvalid = 1'b0;
      chk("sp_req_still_req", 32'(bus.apu_req), 32'd1);
      chk("sp_req_rvalid", 32'(result_valid_o), 32'd0);
      bus.apu_gnt = 1'b1;
      step();
      bus.apu_gnt    = 1'b0;
      bus.apu_rvalid = 1'b1;
      bus.apu_result = 32'h77;
      step();
      bus.apu_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_rvalid_held", 32'(result_valid_o), 32'd1);
         chk("t3_result_held", result_o, 32'h77);
         chk("t3_rd_held", 32'(result_rd_o), 32'd0);
         chk("t3_wb_zero", 32'(result_wb_o), 32'd0);
         chk("t3_ready_low", 32'(instr_ready_o), 32'd0);
         step();
      end
      result_ready_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      chk("t3_rvalid_drop", 32'(result_valid_o), 32'd0);
      chk("t3_count", instr_count_o, 32'd3);
      chk("t3_back_idle", 32'(instr_ready_o), 32'd1);

      // ---- vmv.x.s rd=9, back-to-back 4-cycle turnaround ----
      instr_valid_i = 1'b1;
      instr_i       = 32'h422024D7;
      rd_addr_i     = 5'd9;
      step();
      instr_valid_i = 1'b0;
      bus.apu_gnt   = 1'b1;
      step();
      bus.apu_gnt    = 1'b0;
      bus.apu_rvalid = 1'b1;
      bus.apu_result = 32'h12345678;
      step();
      bus.apu_rvalid = 1'b0;
      chk("t4_result", result_o, 32'h12345678);
      chk("t4_rd", 32'(result_rd_o), 32'd9);
      chk("t4_wb", 32'(result_wb_o), 32'd1);
      result_ready_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      chk("t4_count", instr_count_o, 32'd4);
      chk("t4_idle", 32'(instr_ready_o), 32'd1);

      // ---- reset during WAIT_RSP ----
      instr_valid_i = 1'b1;
      instr_i       = 32'h0C0572D7;
      rs1_i         = 32'd9;
      rd_addr_i     = 5'd5;
      flags_i       = 15'h0F0F;
      step();
      instr_valid_i = 1'b0;
      bus.apu_gnt   = 1'b1;
      step();
      bus.apu_gnt = 1'b0;
      chk("t5_in_wait", 32'(busy_o), 32'd1);
      n_reset = 1'b0;
      #1;
      chk("t5_rst_req", 32'(bus.apu_req), 32'd0);
      chk("t5_rst_busy", 32'(busy_o), 32'd0);
      chk("t5_rst_ready", 32'(instr_ready_o), 32'd0);
      chk("t5_rst_count", instr_count_o, 32'd0);
      chk("t5_rst_result", result_o, 32'd0);
      chk("t5_rst_opnd0", bus.apu_operands[0], 32'd0);
      chk("t5_rst_flags", 32'(bus.apu_flags_o), 32'd0);
      bus.apu_rvalid = 1'b1;
      bus.apu_result = 32'h99;
      step();
      bus.apu_rvalid = 1'b0;
      n_reset = 1'b1;
      #1;
      chk("t5_no_result", 32'(result_valid_o), 32'd0);
      instr_valid_i = 1'b1;
      step();
      instr_valid_i = 1'b0;
      bus.apu_gnt   = 1'b1;
      step();
      bus.apu_gnt    = 1'b0;
      bus.apu_rvalid = 1'b1;
      bus.apu_result = 32'd8;
      step();
      bus.apu_rvalid = 1'b0;
      chk("t5_result", result_o, 32'd8);
      chk("t5_wb", 32'(result_wb_o), 32'd1);
      result_ready_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      chk("t5_count", instr_count_o, 32'd1);

`ifdef APU_TIMEOUT_EN
      // ---- watchdog: no rvalid, TIMEOUT_CYCLES=16 ----
      begin
         int n;
         instr_valid_i = 1'b1;
         step();
         instr_valid_i = 1'b0;
         bus.apu_gnt   = 1'b1;
         step();
         bus.apu_gnt = 1'b0;
         n = 1;
         while (!result_valid_o && n < 40) begin
            step();
            n++;
         end
         chk("tmo_latency", 32'(n), 32'd17);
         chk("tmo_result", result_o, 32'd0);
         chk("tmo_wb", 32'(result_wb_o), 32'd0);
         chk("tmo_err", 32'(timeout_err_o), 32'd1);
         result_ready_i = 1'b1;
         step();
         result_ready_i = 1'b0;
         bus.apu_rvalid = 1'b1;
         bus.apu_result = 32'hAB;
         step();
         bus.apu_rvalid = 1'b0;
         chk("tmo_late_ignored", 32'(result_valid_o), 32'd0);
         chk("tmo_err_sticky", 32'(timeout_err_o), 32'd1);
         chk("tmo_count", instr_count_o, 32'd2);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
